// File: rtl/led_pattern_sequencer.sv
// Animates the LED PIO from a small CSR block; strobe appears one cycle after enable, then every max(PERIOD,1) cycles.
// The PIO is zero-wait, so there is no backpressure: every strobe is a single-cycle write to address 0.
module led_pattern_sequencer #(
  parameter int LED_WIDTH    = 8,
  parameter int PERIOD_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [PERIOD_WIDTH-1:0] CNT_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_q, state_d;
  logic [2:0]              ctrl_q;
  logic [PERIOD_WIDTH-1:0] period_q;
  logic [LED_WIDTH-1:0]    seed_q;
  logic [LED_WIDTH-1:0]    pattern_q, pattern_d;
  logic                    dir_q, dir_d;
  logic [PERIOD_WIDTH-1:0] counter_q, counter_d;
  logic                    strobe_q, strobe_d;

  logic                    csr_wr, ctrl_wr, seed_wr;
  logic                    en_next;
  logic [1:0]              mode;
  logic [PERIOD_WIDTH-1:0] period_m1;
  logic                    terminal;
  logic [LED_WIDTH-1:0]    step_pat;
  logic                    step_dir;
  logic [LED_WIDTH+7:0]    status;

  assign csr_wr    = chipselect && !write_n;
  assign ctrl_wr   = csr_wr && (address == 2'd0);
  assign seed_wr   = csr_wr && (address == 2'd2);
  assign en_next   = ctrl_wr ? writedata[0] : ctrl_q[0];
  assign mode      = ctrl_q[2:1];
  assign period_m1 = (period_q == '0) ? '0 : period_q - CNT_ONE;
  assign terminal  = (counter_q == period_m1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q   <= '0;
      period_q <= '0;
      seed_q   <= '0;
    end else if (csr_wr) begin
      case (address)
        2'd0:    ctrl_q   <= writedata[2:0];
        2'd1:    period_q <= writedata[PERIOD_WIDTH-1:0];
        2'd2:    seed_q   <= writedata[LED_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Next pattern for the current mode; an all-zero pattern never lights up.
  always_comb begin
    step_pat = pattern_q;
    step_dir = dir_q;
    case (mode)
      2'd1: step_pat = {pattern_q[LED_WIDTH-2:0], pattern_q[LED_WIDTH-1]};
      2'd2: begin
        if (!dir_q && pattern_q[LED_WIDTH-1]) begin
          step_dir = 1'b1;
          step_pat = pattern_q >> 1;
        end else if (dir_q && pattern_q[0]) begin
          step_dir = 1'b0;
          step_pat = pattern_q << 1;
        end else begin
          step_pat = dir_q ? (pattern_q >> 1) : (pattern_q << 1);
        end
      end
      2'd3: step_pat = ~pattern_q;
      default: ;
    endcase
    if (pattern_q == '0) step_pat = '0;
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    dir_d     = dir_q;
    counter_d = counter_q;
    strobe_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ctrl_q[0] && en_next) begin
          state_d   = LOAD;
          pattern_d = seed_wr ? writedata[LED_WIDTH-1:0] : seed_q;
          dir_d     = 1'b0;
          counter_d = '0;
          strobe_d  = 1'b1;
        end
      end
      LOAD, RUN: begin
        state_d = RUN;
        // A seed write restarts immediately and pre-empts any step due this cycle.
        if (seed_wr) begin
          state_d   = LOAD;
          pattern_d = writedata[LED_WIDTH-1:0];
          dir_d     = 1'b0;
          counter_d = '0;
          strobe_d  = 1'b1;
        end else begin
          if (terminal) begin
            counter_d = '0;
            if (mode != 2'd0) begin
              pattern_d = step_pat;
              dir_d     = step_dir;
              strobe_d  = 1'b1;
            end
          end else begin
            counter_d = counter_q + CNT_ONE;
          end
          if (!en_next) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pattern_q <= '0;
      dir_q     <= 1'b0;
      counter_q <= '0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      dir_q     <= dir_d;
      counter_q <= counter_d;
      strobe_q  <= strobe_d;
    end
  end

  assign status = {pattern_q, 6'b0, dir_q, (state_q != IDLE)};

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata = 32'(ctrl_q);
      2'd1:    readdata = 32'(period_q);
      2'd2:    readdata = 32'(seed_q);
      default: readdata = 32'(status);
    endcase
  end

  assign pio_address    = 2'b00;
  assign pio_chipselect = strobe_q;
  assign pio_write_n    = ~strobe_q;
  assign pio_writedata  = 32'(pattern_q);

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer: strobes are logged by a monitor, each test checks the log.
module tb_led_pattern_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int q_cyc[$];
  logic [31:0] q_dat[$];
  logic [31:0] q_st[$];

  led_pattern_sequencer #(.LED_WIDTH(8), .PERIOD_WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata)
  );

  always #5 clk = ~clk;

  // Strobe log: cycle index (posedges seen), data and the STATUS read at that time.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #2;
    if (pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
      q_cyc.push_back(cyc);
      q_dat.push_back(pio_writedata);
      q_st.push_back(readdata);
    end
  end

  task automatic clear_log();
    q_cyc.delete();
    q_dat.delete();
    q_st.delete();
  endtask

  // Called at a negedge; the write is captured at the next posedge, wc returns that posedge index.
  task automatic csr_write(input logic [1:0] a, input logic [31:0] d, output int wc);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd3;
    writedata  = '0;
    wc = cyc;
  endtask

  task automatic disable_seq();
    int wc;
    csr_write(2'd0, 32'h0, wc);
    repeat (2) @(negedge clk);
    clear_log();
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (3) @(negedge clk);
    checks++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'h0 || pio_address !== 2'b00) begin
      errors++;
      $display("FAIL reset_outputs: cs=%b wn=%b wd=%h addr=%h, required cs=0 wn=1 wd=0 addr=0",
               pio_chipselect, pio_write_n, pio_writedata, pio_address);
    end
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      rd = readdata;
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_readback addr=%0d: got %h, required 00000000", a, rd);
      end
    end
    address = 2'd3;
    @(negedge clk);
  endtask

  task automatic test_rotate();
    int wc, n;
    logic [7:0]  exp [4];
    logic [31:0] rb  [3];
    exp = '{8'h81, 8'h03, 8'h06, 8'h0C};
    rb  = '{32'h3, 32'h4, 32'h81};
    csr_write(2'd2, 32'h81, wc);
    csr_write(2'd1, 32'd4, wc);
    clear_log();
    csr_write(2'd0, 32'h3, n);
    repeat (16) @(negedge clk);
    checks++;
    if (q_dat.size() < 4) begin
      errors++;
      $display("FAIL rotate_count: got %0d strobes, required at least 4", q_dat.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_dat[i] !== {24'h0, exp[i]} || q_cyc[i] != n + 1 + 4 * i) begin
          errors++;
          $display("FAIL rotate_step%0d: got %h at cycle %0d, required %h at cycle %0d",
                   i, q_dat[i], q_cyc[i], exp[i], n + 1 + 4 * i);
        end
      end
    end
    for (int a = 0; a < 3; a++) begin
      address = 2'(a);
      #1;
      checks++;
      if (readdata !== rb[a]) begin
        errors++;
        $display("FAIL rotate_readback addr=%0d: got %h, required %h", a, readdata, rb[a]);
      end
    end
    address = 2'd3;
    disable_seq();
  endtask

  task automatic test_bounce();
    int wc, n;
    logic [7:0] pat [11];
    logic       dir [11];
    logic [31:0] st;
    pat = '{8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};
    dir = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    csr_write(2'd2, 32'h40, wc);
    csr_write(2'd1, 32'd1, wc);
    clear_log();
    csr_write(2'd0, 32'h5, n);
    repeat (12) @(negedge clk);
    checks++;
    if (q_dat.size() < 11) begin
      errors++;
      $display("FAIL bounce_count: got %0d strobes, required at least 11", q_dat.size());
    end else begin
      for (int i = 0; i < 11; i++) begin
        st = {16'h0, pat[i], 6'b0, dir[i], 1'b1};
        checks++;
        if (q_dat[i] !== {24'h0, pat[i]} || q_cyc[i] != n + 1 + i || q_st[i] !== st) begin
          errors++;
          $display("FAIL bounce_step%0d: got data %h status %h cycle %0d, required data %h status %h cycle %0d",
                   i, q_dat[i], q_st[i], q_cyc[i], pat[i], st, n + 1 + i);
        end
      end
    end
    disable_seq();
  endtask

  task automatic test_blink_period0();
    int wc, n;
    logic [7:0] exp;
    csr_write(2'd1, 32'd0, wc);
    csr_write(2'd2, 32'hA5, wc);
    clear_log();
    csr_write(2'd0, 32'h7, n);
    repeat (8) @(negedge clk);
    checks++;
    if (q_dat.size() < 6) begin
      errors++;
      $display("FAIL blink_count: got %0d strobes, required at least 6", q_dat.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        exp = (i % 2 == 0) ? 8'hA5 : 8'h5A;
        checks++;
        if (q_dat[i] !== {24'h0, exp} || q_cyc[i] != n + 1 + i) begin
          errors++;
          $display("FAIL blink_step%0d: got %h at cycle %0d, required %h at cycle %0d",
                   i, q_dat[i], q_cyc[i], exp, n + 1 + i);
        end
      end
    end
    disable_seq();
  endtask

  task automatic test_static_disable();
    int wc, n;
    csr_write(2'd2, 32'h3C, wc);
    clear_log();
    csr_write(2'd0, 32'h1, n);
    repeat (100) @(negedge clk);
    checks++;
    if (q_dat.size() != 1) begin
      errors++;
      $display("FAIL static_count: got %0d strobes, required 1", q_dat.size());
    end else begin
      checks++;
      if (q_dat[0] !== 32'h3C || q_cyc[0] != n + 1) begin
        errors++;
        $display("FAIL static_data: got %h at cycle %0d, required 0000003c at cycle %0d", q_dat[0], q_cyc[0], n + 1);
      end
    end
    #1;
    checks++;
    if (readdata !== 32'h3C01) begin
      errors++;
      $display("FAIL static_status_running: got %h, required 00003c01", readdata);
    end
    clear_log();
    csr_write(2'd0, 32'h0, wc);
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (readdata !== 32'h3C00) begin
      errors++;
      $display("FAIL static_status_stopped: got %h, required 00003c00", readdata);
    end
    checks++;
    if (q_dat.size() != 0) begin
      errors++;
      $display("FAIL static_after_disable: got %0d strobes, required 0", q_dat.size());
    end
  endtask

  task automatic test_seed_collision();
    int wc, n;
    logic [7:0] exp [4];
    int         off [4];
    int         bad;
    exp = '{8'h01, 8'h02, 8'h55, 8'hAA};
    off = '{1, 4, 7, 10};
    csr_write(2'd2, 32'h01, wc);
    csr_write(2'd1, 32'd3, wc);
    clear_log();
    csr_write(2'd0, 32'h3, n);
    repeat (6) @(negedge clk);
    csr_write(2'd2, 32'h55, wc);
    repeat (6) @(negedge clk);
    checks++;
    if (q_dat.size() < 4) begin
      errors++;
      $display("FAIL collision_count: got %0d strobes, required at least 4", q_dat.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_dat[i] !== {24'h0, exp[i]} || q_cyc[i] != n + off[i]) begin
          errors++;
          $display("FAIL collision_step%0d: got %h at cycle %0d, required %h at cycle %0d",
                   i, q_dat[i], q_cyc[i], exp[i], n + off[i]);
        end
      end
    end
    bad = 0;
    foreach (q_dat[i]) if (q_dat[i] === 32'h04) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL collision_dropped_step: got %0d strobes of 04, required 0", bad);
    end
    disable_seq();
  endtask

  task automatic test_async_reset();
    int wc;
    csr_write(2'd1, 32'd1, wc);
    csr_write(2'd2, 32'hA5, wc);
    csr_write(2'd0, 32'h7, wc);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (pio_chipselect !== 1'b1) begin
      errors++;
      $display("FAIL reset_precondition: got cs=%b, required 1", pio_chipselect);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (pio_chipselect !== 1'b0 || pio_write_n !== 1'b1 || pio_writedata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_strobe: cs=%b wn=%b wd=%h, required cs=0 wn=1 wd=0",
               pio_chipselect, pio_write_n, pio_writedata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      checks++;
      if (readdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_release_readback addr=%0d: got %h, required 00000000", a, readdata);
      end
    end
    address = 2'd3;
    @(negedge clk);
    clear_log();
    repeat (10) @(negedge clk);
    checks++;
    if (q_dat.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: got %0d strobes after reset, required 0", q_dat.size());
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd3;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    test_reset();
    test_rotate();
    test_bounce();
    test_blink_period0();
    test_static_disable();
    test_seed_collision();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
